// File: rtl/aes_cbc_decipher_ctrl.sv
// CBC chaining controller around the AES decipher round block: feeds ciphertext to the
// core, XORs the raw result with the chaining value and streams out plaintext.
module aes_cbc_decipher_ctrl #(
  parameter int unsigned WAIT_MAX = 127
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         iv_we,
  input  logic [127:0] iv,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic         dec_next,
  output logic [127:0] dec_block,
  input  logic         dec_ready,
  input  logic [127:0] dec_new_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic [31:0]  blk_count,
  output logic         error
);

  localparam int unsigned CTR_W     = 8;
  localparam logic [CTR_W-1:0] WAIT_LAST = CTR_W'(WAIT_MAX - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t             state;
  logic [127:0]       ct_reg;
  logic [127:0]       chain_reg;
  logic [127:0]       pt_reg;
  logic [CTR_W-1:0]   wait_ctr;
  logic [31:0]        blk_ctr;
  logic               err_reg;
  logic               dec_next_r;
  logic               out_valid_r;

  // Acceptance must follow the core's ready level in the same cycle.
  assign in_ready  = (state == IDLE) && !err_reg && dec_ready;
  assign dec_next  = dec_next_r;
  assign out_valid = out_valid_r;
  assign dec_block = ct_reg;
  assign out_block = pt_reg;
  assign blk_count = blk_ctr;
  assign error     = err_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ct_reg      <= '0;
      chain_reg   <= '0;
      pt_reg      <= '0;
      wait_ctr    <= '0;
      blk_ctr     <= '0;
      err_reg     <= 1'b0;
      dec_next_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iv_we) begin
            chain_reg <= iv;
            blk_ctr   <= '0;
            err_reg   <= 1'b0;
          end
          if (in_valid && in_ready) begin
            ct_reg     <= in_block;
            dec_next_r <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          dec_next_r <= 1'b0;
          wait_ctr   <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          if (dec_ready) begin
            pt_reg      <= dec_new_block ^ chain_reg;
            chain_reg   <= ct_reg;
            blk_ctr     <= blk_ctr + 32'd1;
            out_valid_r <= 1'b1;
            state       <= OUT;
          end else if (wait_ctr == WAIT_LAST) begin
            // Core never finished: drop the block, keep chaining state intact.
            err_reg <= 1'b1;
            state   <= IDLE;
          end else begin
            wait_ctr <= wait_ctr + CTR_W'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_cbc_decipher_ctrl.sv
// Bench for aes_cbc_decipher_ctrl: behavioural decipher core, queue scoreboard and
// directed scenarios (NIST CBC vectors, latency, backpressure, IV+accept, reset, timeout).
module tb_aes_cbc_decipher_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         iv_we;
  logic [127:0] iv;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic         dec_next;
  logic [127:0] dec_block;
  logic         dec_ready;
  logic [127:0] dec_new_block;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;
  logic [31:0]  blk_count;
  logic         error;

  aes_cbc_decipher_ctrl #(.WAIT_MAX(127)) dut (
    .clk(clk), .reset(reset), .iv_we(iv_we), .iv(iv),
    .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
    .dec_next(dec_next), .dec_block(dec_block), .dec_ready(dec_ready),
    .dec_new_block(dec_new_block), .out_valid(out_valid), .out_ready(out_ready),
    .out_block(out_block), .blk_count(blk_count), .error(error)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] NIST_IV = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] C2 = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] P1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [127:0] blk;
    logic [31:0]  cnt;
  } exp_t;
  exp_t sb[$];

  // Behavioural decipher core: raw AES decryption of the NIST ciphertexts, ~block otherwise.
  int  lat = 4;
  bit  hang = 1'b0;
  bit  zero_mode = 1'b0;
  int  dcnt;

  function automatic logic [127:0] raw_of(input logic [127:0] c);
    if (zero_mode) return '0;
    if (c == C1) return P1 ^ NIST_IV;
    if (c == C2) return P2 ^ C1;
    return ~c;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      dec_ready     <= 1'b1;
      dec_new_block <= '0;
      dcnt          <= 0;
    end else if (dec_next) begin
      dec_ready <= 1'b0;
      dcnt      <= lat;
    end else if (!dec_ready && !hang) begin
      if (dcnt <= 1) begin
        dec_ready     <= 1'b1;
        dec_new_block <= raw_of(dec_block);
      end else begin
        dcnt <= dcnt - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Scoreboard monitor: every accepted plaintext is popped and compared.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: got %h with no expected entry", out_block);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (out_block !== e.blk || blk_count !== e.cnt) begin
          fails++;
          $display("FAIL plaintext: got %h/%0d expected %h/%0d",
                   out_block, blk_count, e.blk, e.cnt);
        end
      end
    end
  end

  task automatic push(input logic [127:0] b, input logic [31:0] c);
    exp_t e;
    e.blk = b;
    e.cnt = c;
    sb.push_back(e);
  endtask

  task automatic send(input logic [127:0] b);
    int n;
    in_block = b;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 500);
    if (!in_ready) chk("send_timeout", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic load_iv(input logic [127:0] v);
    iv    = v;
    iv_we = 1'b1;
    @(posedge clk);
    #1 iv_we = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    #1 chk("drain", 128'(sb.size()), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen_ov;
    logic [127:0] held;

    reset = 1'b1; iv_we = 1'b0; iv = '0; in_valid = 1'b0; in_block = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_dec_next", 128'(dec_next), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_error", 128'(error), 128'd0);
    chk("rst_blk_count", 128'(blk_count), 128'd0);
    chk("rst_out_block", out_block, 128'd0);
    @(posedge clk); #1;

    // NIST SP800-38A CBC-AES128 chain
    load_iv(NIST_IV);
    push(P1, 32'd1);
    send(C1);
    drain();
    push(P2, 32'd2);
    send(C2);
    drain();

    // Latency: 50-cycle core, dec_next one cycle after acceptance
    lat = 50;
    push(~128'h0123456789abcdef0011223344556677 ^ C2, 32'd3);
    send(128'h0123456789abcdef0011223344556677);
    @(negedge clk);
    chk("lat_dec_next", 128'(dec_next), 128'd1);
    n = 0;
    do begin
      @(negedge clk);
      if (!dec_ready) n++;
    end while (!dec_ready && n < 1000);
    chk("lat_ready_low_cycles", 128'(n), 128'd50);
    chk("lat_out_valid_before", 128'(out_valid), 128'd0);
    @(negedge clk);
    chk("lat_out_valid_after", 128'(out_valid), 128'd1);
    drain();

    // Backpressure: 20 cycles of out_ready low, second block offered meanwhile
    lat = 5;
    out_ready = 1'b0;
    push(~128'h11111111222222223333333344444444 ^ 128'h0123456789abcdef0011223344556677, 32'd4);
    send(128'h11111111222222223333333344444444);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 500);
    chk("bp_out_valid", 128'(out_valid), 128'd1);
    held = out_block;
    @(posedge clk);
    #1 in_block = 128'h5555aaaa5555aaaa5555aaaa5555aaaa;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_out_block_stable", out_block, held);
      chk("bp_in_ready_low", 128'(in_ready), 128'd0);
    end
    push(~128'h5555aaaa5555aaaa5555aaaa5555aaaa ^ 128'h11111111222222223333333344444444, 32'd5);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_in_ready_after", 128'(in_ready), 128'd1);
    chk("bp_dec_next_not_yet", 128'(dec_next), 128'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_dec_next_taken", 128'(dec_next), 128'd1);
    drain();

    // Simultaneous IV load and acceptance
    zero_mode = 1'b1;
    push({128{1'b1}}, 32'd1);
    @(negedge clk);
    chk("sim_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1 iv = {128{1'b1}};
    iv_we = 1'b1;
    in_block = 128'hdeadbeef;
    in_valid = 1'b1;
    @(posedge clk);
    #1 iv_we = 1'b0;
    in_valid = 1'b0;
    drain();
    zero_mode = 1'b0;

    // Reset mid-WAIT
    lat = 50;
    send(128'hcafef00d);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rwait_in_ready", 128'(in_ready), 128'd1);
    chk("rwait_out_valid", 128'(out_valid), 128'd0);
    chk("rwait_blk_count", 128'(blk_count), 128'd0);
    chk("rwait_dec_next", 128'(dec_next), 128'd0);
    @(posedge clk); #1;

    // Timeout: core never completes
    hang = 1'b1;
    lat = 3;
    send(128'h0badf00d);
    n = 0;
    seen_ov = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (out_valid) seen_ov = 1'b1;
    end while (!error && n < 400);
    chk("to_error_cycle", 128'(n), 128'd129);
    chk("to_no_output", 128'(seen_ov), 128'd0);
    hang = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dec_ready && n < 100);
    chk("to_in_ready_low", 128'(in_ready), 128'd0);
    chk("to_error_sticky", 128'(error), 128'd1);
    chk("to_blk_count_kept", 128'(blk_count), 128'd0);
    @(posedge clk);
    #1 load_iv('0);
    @(negedge clk);
    chk("to_error_cleared", 128'(error), 128'd0);
    chk("to_in_ready_back", 128'(in_ready), 128'd1);

    chk("sb_empty", 128'(sb.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/aes_cbc_decipher_ctrl.md
# aes_cbc_decipher_ctrl

CBC-mode chaining controller wrapped around the AES decipher round block. It accepts ciphertext blocks on a valid/ready stream and drives the decipher block's `next`/`block` inputs. When the decipher block reports ready, it XORs the raw result with the chaining value (the IV or the previous ciphertext) and presents the plaintext on a valid/ready output stream. It also tracks completed blocks and flags a decipher core that never completes.

## Interface
- `WAIT_MAX`, default 127: maximum number of cycles spent in WAIT before a timeout is declared. Valid range is 1..255.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high reset.
- `iv_we` in 1: loads the IV. Honoured only in IDLE.
- `iv` in 128: initialisation vector.
- `in_valid` in 1: ciphertext valid.
- `in_ready` out 1: high when the controller can accept a ciphertext block.
- `in_block` in 128: ciphertext block.
- `dec_next` out 1: one-cycle start pulse to the decipher block.
- `dec_block` out 128: held ciphertext, driven to the decipher block's `block` input.
- `dec_ready` in 1: decipher block ready.
- `dec_new_block` in 128: decipher block result.
- `out_valid` out 1: plaintext valid.
- `out_ready` in 1: downstream accepts the plaintext.
- `out_block` out 128: plaintext.
- `blk_count` out 32: number of blocks completed since the last IV load.
- `error` out 1: sticky timeout flag.

## Operation
- Registers:
  - `ct_reg` [128]: held ciphertext.
  - `chain_reg` [128]: chaining value.
  - `pt_reg` [128]: plaintext.
  - `wait_ctr` [8]: WAIT cycle counter.
  - `blk_ctr` [32]: block counter.
  - `err_reg`: error flag.
  - `state` [2]: FSM state.
- Reset values: state IDLE, all data registers 0, `err_reg` 0. After reset, outputs are:
  - `in_ready` 1 and `dec_next` 0.
  - `out_valid` 0 and `error` 0.
  - `blk_count` 0 and `out_block` 0.
- `dec_block` = `ct_reg` at all times. It stays stable from acceptance through completion, because the decipher block samples it one cycle after `next`.
- `out_block` = `pt_reg`; `blk_count` = `blk_ctr`; `error` = `err_reg`.
- FSM, states IDLE(0), START(1), WAIT(2), OUT(3):
  - IDLE:
    - `in_ready` = !`err_reg` & `dec_ready`.
    - When `in_valid` & `in_ready`: `ct_reg` <= `in_block`, then go to START.
    - When `iv_we`: `chain_reg` <= `iv`, `blk_ctr` <= 0, `err_reg` <= 0.
  - START:
    - `dec_next` = 1 for exactly this cycle.
    - `wait_ctr` <= 0, then go to WAIT.
  - WAIT, if `dec_ready` = 1:
    - `pt_reg` <= `dec_new_block` ^ `chain_reg`.
    - `chain_reg` <= `ct_reg`.
    - `blk_ctr` <= `blk_ctr`+1, wrapping modulo 2^32.
    - Go to OUT.
  - WAIT, else if `wait_ctr` == `WAIT_MAX`-1:
    - `err_reg` <= 1, then go to IDLE.
    - No output is produced; `chain_reg` and `blk_ctr` are unchanged.
  - WAIT, otherwise: `wait_ctr`++.
  - OUT:
    - `out_valid` = 1.
    - On `out_ready`, go to IDLE.
- Outside IDLE: `in_ready` = 0, and `iv_we` is ignored (no register change).
- Simultaneous `iv_we` and block acceptance in IDLE: both take effect. The accepted block chains with the newly loaded `iv`.
- While `err_reg` = 1, no block is accepted. Only `iv_we` (or `reset`) clears the error.
- `reset` asserted in any state, including mid-decipher: return to IDLE with the reset values on the next edge. The decipher block is assumed reset by the same reset domain.

## Timing
- Cycle 0: `in_valid` & `in_ready` sampled high. Cycle 1: START, `dec_next` = 1. Cycle 2: WAIT begins.
- `dec_ready` is sampled only in WAIT. The decipher block has already dropped ready by cycle 2, so the stale ready level from cycle 1 is never observed.
- If `dec_ready` is first high in WAIT cycle n, then `out_valid` = 1 from cycle n+1.
- `out_valid`, `out_block` and `blk_count` stay stable until the cycle in which `out_ready` is sampled high. The next acceptance is possible the following cycle.
- Throughput is one block per (decipher latency + 3 + output stall) cycles. There is no overlap between blocks.
- Timeout: `error` rises on the cycle after the `WAIT_MAX`-th WAIT cycle without `dec_ready`.

## Test plan
- NIST SP800-38A CBC-AES128 vectors:
  - Stimulus: load IV 000102030405060708090a0b0c0d0e0f, then stream ciphertexts 7649abac8119b246cee98e9b12e9197d and 5086cb9b507219ee95db113a917678b2, with key 2b7e1516… on the real decipher block.
  - Required response: 6bc1bee22e409f96e93d7e117393172a, then ae2d8a571e03ac9c9eb76fac45af8e51, with `blk_count` 1 then 2.
- Latency with a behavioural decipher model (`dec_ready` low for exactly 50 cycles after `next`):
  - `dec_next` is seen exactly 1 cycle after acceptance.
  - `out_valid` is seen exactly 1 cycle after `dec_ready` returns high.
- Backpressure:
  - Stimulus: hold `out_ready` = 0 for 20 cycles.
  - Required response: `out_block` is stable, `in_ready` = 0, and a second ciphertext offered meanwhile is not taken until 1 cycle after `out_ready`.
- Simultaneous IV load and acceptance in IDLE:
  - Stimulus: `iv_we` and the block acceptance in the same cycle, with `iv` = all-ones and a model returning 0.
  - Required response: `out_block` = ffff…ff and `blk_count` = 1.
- Timeout:
  - Stimulus: the model never raises `dec_ready`, with `WAIT_MAX` = 127.
  - Required response: `error` = 1 after 127 WAIT cycles, `in_ready` = 0, `out_valid` never asserted, and a later `iv_we` clears `error` and restores `in_ready`.
- Reset mid-WAIT:
  - Stimulus: `reset` asserted during WAIT.
  - Required response: the next cycle shows `in_ready` = 1, `out_valid` = 0, `blk_count` = 0, `dec_next` = 0.
